fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin packet arbiter that shares the async FIFO write port among NREQ requesters in the w_clk domain.
- It grants one requester at a time and holds that grant until the packet's last beat, or until a burst cap is reached.
- It gates every beat with the FIFO full flag and drives the FIFO's w_en and write data.
- It sits between the producer clients and the FIFO write-pointer/memory write logic.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, data width per beat.
- MAX_BURST, 16, maximum beats per grant; 0 = unlimited, grant held until last.
- IDW, 2, width of grant_id; must be at least clog2(NREQ).

Ports:
- w_clk  in  1  write-domain clock.
- w_rst  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester beat valid.
- req_data  in  NREQ*DW  packed beat data; requester i occupies bits [i*DW +: DW].
- req_last  in  NREQ  per-requester last-beat-of-packet flag.
- req_ready  out  NREQ  per-requester beat accepted this cycle (when valid).
- full  in  1  FIFO full flag from the write-pointer block, w_clk domain.
- w_en  out  1  FIFO write enable.
- w_data  out  DW  FIFO write data.
- grant_id  out  IDW  index of the current grant owner.
- busy  out  1  grant held (state LOCKED).
- ovf_drop  out  1  sticky: a beat was presented with w_en while full was high (must never occur); cleared by reset only.

Behaviour:
- Reset (w_rst=0, async):
  - state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, busy=0, ovf_drop=0.
  - req_ready=0, w_en=0, w_data=0.
  - Reset mid-packet abandons the packet; there is no resume.
- States: IDLE, LOCKED.
- IDLE:
  - req_ready=0 and w_en=0.
  - If any req_valid is set, select the first set bit searching from rr_ptr upward with wrap-around.
  - Register grant_id, go to LOCKED, clear beat_cnt.
  - Arbitration latency: 1 cycle from req_valid to the first req_ready.
- LOCKED:
  - req_ready[grant_id] = ~full; all other req_ready bits = 0.
  - A beat is accepted when req_valid[g] & req_ready[g].
  - On acceptance: w_en=1 and w_data=req_data[g] in the same cycle (combinational, zero latency). w_en is never asserted while full=1.
  - req_valid[g] dropping mid-packet keeps the grant; no timeout.
- Release (on accepted beat with req_last[g]=1, or beat_cnt+1==MAX_BURST when MAX_BURST≠0):
  - Next cycle: state=IDLE, rr_ptr=(g+1) mod NREQ, beat_cnt=0.
  - One IDLE bubble occurs per grant.
- Burst-capped release:
  - The requester's packet continues on its next grant, which is round-robin fair.
  - The FIFO consumer must tolerate interleaved packets, or MAX_BURST is set to 0.
- Full handling:
  - full=1 stalls the owner with req_ready=0.
  - The grant and beat_cnt are held; full toggling mid-packet does not lose or duplicate beats.
- Ordering: all beats of one grant are written in order, contiguously with stalls only.
- Width rules:
  - beat_cnt width is clog2(MAX_BURST+1), minimum 1.
  - rr_ptr is IDW wide and wraps at NREQ, not at 2^IDW.
- ovf_drop is a safety monitor only: set if w_en & full.

Decomposition:
- Shared package fifo_pkg holds:
  - the state enum (IDLE, LOCKED);
  - a function clog2;
  - a function rr_pick(req, ptr) returning index and found flag.
- One sub-module is natural: rr_priority_picker (parameterised NREQ, combinational rotate / find-first / un-rotate). It is reusable by the read side.

Test Plan:
- Reset: hold w_rst=0 with req_valid=4'b1111 → all outputs 0; release → grant_id=0 one cycle later, busy=1.
- Round-robin: all 4 requesters send 2-beat packets (last on beat 2) continuously, full=0 → grants 0,1,2,3,0; each grant gives 2 w_en cycles then 1 idle; w_data matches the owner's bytes in order.
- Full stall: requester 2 sends 4 beats 8'hA0..A3 with full=1 for 3 cycles during beat 2 → req_ready=0 and w_en=0 during the stall; w_data sequence exactly A0,A1,A2,A3; ovf_drop stays 0.
- Burst cap: MAX_BURST=16, requester 1 sends a 20-beat packet while requester 3 waits → 16 beats from 1, idle, requester 3's packet, idle, remaining 4 beats from 1.
- Skip/wrap: only req_valid[3] and req_valid[0] set, rr_ptr=3 → grant 3, then 0 (pointer wraps).
- Mid-packet reset: assert w_rst=0 after beat 2 of 5 → w_en and req_ready drop immediately; after release, arbitration restarts from rr_ptr=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO write/read arbitration slice.
package fifo_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int unsigned PICK_MAX = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  function automatic int clog2(input int unsigned value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // First set bit of req at or above ptr, wrapping at nreq (ptr must be < nreq).
  function automatic pick_t rr_pick(input logic [PICK_MAX-1:0] req,
                                    input logic [2:0]          ptr,
                                    input int unsigned         nreq);
    pick_t       p;
    int unsigned idx;
    p = '0;
    for (int unsigned k = 0; k < PICK_MAX; k++) begin
      idx = {29'd0, ptr} + k;
      if (idx >= nreq) idx = idx - nreq;
      if (!p.found && (k < nreq) && req[idx[2:0]]) begin
        p.found = 1'b1;
        p.idx   = idx[2:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_picker.sv
// Round-robin priority picker: rotate by ptr, find first request, map back to an index.
module rr_priority_picker
  import fifo_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [PW-1:0]   idx_o,
  output logic            found_o
);

  logic [PICK_MAX-1:0] req_ext;
  logic [2:0]          ptr_ext;
  pick_t               pick;

  always_comb begin
    req_ext             = '0;
    req_ext[NREQ-1:0]   = req_i;
    ptr_ext             = 3'(ptr_i);
    pick                = rr_pick(req_ext, ptr_ext, NREQ);
    idx_o               = PW'(pick.idx);
    found_o             = pick.found;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter sharing the async FIFO write port among NREQ producers.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16,
  parameter int IDW       = 2
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  input  logic              full,
  output logic              w_en,
  output logic [DW-1:0]     w_data,
  output logic [IDW-1:0]    grant_id,
  output logic              busy,
  output logic              ovf_drop
);

  localparam int BCW = (clog2(MAX_BURST + 1) < 1) ? 1 : clog2(MAX_BURST + 1);

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
  logic           ovf_drop_q;

  logic [IDW-1:0] pick_idx;
  logic           pick_found;
  logic           own_valid, own_last, accept, cap_hit, release_now;
  logic [DW-1:0]  own_data;

  rr_priority_picker #(
    .NREQ (NREQ),
    .PW   (IDW)
  ) u_picker (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Beat path is combinational so an accepted beat reaches the FIFO in the same cycle.
  always_comb begin
    own_valid   = req_valid[grant_id_q];
    own_last    = req_last[grant_id_q];
    own_data    = req_data[int'(grant_id_q)*DW +: DW];
    accept      = (state_q == LOCKED) && !full && own_valid;
    cap_hit     = (MAX_BURST != 0) && ((int'(beat_cnt_q) + 1) == MAX_BURST);
    release_now = accept && (own_last || cap_hit);
    req_ready   = '0;
    if ((state_q == LOCKED) && !full) req_ready[grant_id_q] = 1'b1;
    w_en        = accept;
    w_data      = accept ? own_data : '0;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id_d = pick_idx;
          beat_cnt_d = '0;
          state_d    = LOCKED;
        end
      end
      LOCKED: begin
        if (release_now) begin
          state_d    = IDLE;
          beat_cnt_d = '0;
          rr_ptr_d   = (int'(grant_id_q) == NREQ - 1) ? '0 : grant_id_q + IDW'(1);
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + BCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
      ovf_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
      if (w_en && full) ovf_drop_q <= 1'b1;
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = (state_q == LOCKED);
  assign ovf_drop = ovf_drop_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed table, producer-queue sequences and random traffic vs a model.
module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int DW        = 8;
  localparam int MAX_BURST = 16;
  localparam int IDW       = 2;

  logic        w_clk = 1'b0;
  logic        w_rst;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic        full, w_en, busy, ovf_drop;
  logic [7:0]  w_data;
  logic [1:0]  grant_id;

  always #5 w_clk = ~w_clk;

  fifo_wr_arbiter #(
    .NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST), .IDW(IDW)
  ) dut (
    .w_clk(w_clk), .w_rst(w_rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .full(full), .w_en(w_en),
    .w_data(w_data), .grant_id(grant_id), .busy(busy), .ovf_drop(ovf_drop)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct { int id; int data; } wr_t;
  typedef logic [8:0] beat_t;           // {last, data}
  typedef struct {
    logic rst; logic [3:0] v; logic [3:0] l; logic f;
    logic [3:0] e_ready; logic e_wen; logic [7:0] e_wdata; logic [1:0] e_gid; logic e_busy;
  } vec_t;

  wr_t   wlog[$];
  beat_t pq[NREQ][$];
  vec_t  tbl[16];

  // Reference model: owner (-1 = no grant), next search start, last granted id, beats this grant.
  int   m_owner = -1, m_ptr = 0, m_gid = 0, m_cnt = 0;
  logic m_wen;
  logic [3:0] s_ready;
  logic       s_wen;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step_a(input logic rst, input logic [3:0] v, input logic [3:0] l,
                        input logic [31:0] d, input logic f);
    logic [3:0] e_ready;
    logic [7:0] e_wdata;
    w_rst = rst; req_valid = v; req_last = l; req_data = d; full = f;
    #4;
    if (!rst) begin m_owner = -1; m_ptr = 0; m_gid = 0; m_cnt = 0; end
    e_ready = '0; m_wen = 1'b0; e_wdata = '0;
    if (m_owner >= 0 && !f) begin
      e_ready[m_owner] = 1'b1;
      m_wen = v[m_owner];
      if (m_wen) e_wdata = d[m_owner*8 +: 8];
    end
    cmp("req_ready", 32'(req_ready), 32'(e_ready));
    cmp("w_en", 32'(w_en), 32'(m_wen));
    cmp("w_data", 32'(w_data), 32'(e_wdata));
    cmp("grant_id", 32'(grant_id), 32'(m_gid));
    cmp("busy", 32'(busy), 32'(m_owner >= 0));
    cmp("ovf_drop", 32'(ovf_drop), 32'd0);
    s_ready = req_ready;
    s_wen   = w_en;
    if (w_en) wlog.push_back('{id: int'(grant_id), data: int'(w_data)});
  endtask

  task automatic step_b();
    if (w_rst) begin
      if (m_owner < 0) begin
        for (int k = 0; k < NREQ; k++) begin
          if (req_valid[(m_ptr + k) % NREQ]) begin
            m_owner = (m_ptr + k) % NREQ; m_gid = m_owner; m_cnt = 0;
            break;
          end
        end
      end else if (m_wen) begin
        m_cnt++;
        if (req_last[m_owner] || (MAX_BURST != 0 && m_cnt == MAX_BURST)) begin
          m_ptr = (m_owner + 1) % NREQ; m_owner = -1; m_cnt = 0;
        end
      end
    end
    @(posedge w_clk);
    #1;
  endtask

  task automatic bfm_step(input logic rst, input logic f);
    logic [3:0]  v, l;
    logic [31:0] d;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pq[i].size() > 0) begin
        v[i] = 1'b1; l[i] = pq[i][0][8]; d[i*8 +: 8] = pq[i][0][7:0];
      end
    end
    step_a(rst, v, l, d, f);
    step_b();
    for (int i = 0; i < NREQ; i++) if (v[i] && s_ready[i]) pq[i].delete(0);
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NREQ; i++) if (pq[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic bfm_run(input int budget, output int cycles);
    cycles = 0;
    while (!all_empty() && cycles < budget) begin
      bfm_step(1'b1, 1'b0);
      cycles++;
    end
    cmp("drain_in_budget", 32'(all_empty()), 32'd1);
  endtask

  task automatic check_log(input string name, input wr_t exp[$]);
    cmp({name, "_count"}, 32'(wlog.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < wlog.size(); i++) begin
      cmp({name, "_id"}, 32'(wlog[i].id), 32'(exp[i].id));
      cmp({name, "_data"}, 32'(wlog[i].data), 32'(exp[i].data));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t exp[$];
    int  cyc, b, stall;
    logic f;

    //            rst   v      l      f     ready  wen   wdata  gid   busy
    tbl[0]  = '{1'b0, 4'hF, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 4'hF, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[2]  = '{1'b1, 4'hF, 4'h0, 1'b0, 4'h1, 1'b1, 8'h11, 2'd0, 1'b1};
    tbl[3]  = '{1'b1, 4'hF, 4'h1, 1'b0, 4'h1, 1'b1, 8'h11, 2'd0, 1'b1};
    tbl[4]  = '{1'b1, 4'hF, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[5]  = '{1'b1, 4'hF, 4'h2, 1'b1, 4'h0, 1'b0, 8'h00, 2'd1, 1'b1};
    tbl[6]  = '{1'b1, 4'hF, 4'h2, 1'b0, 4'h2, 1'b1, 8'h22, 2'd1, 1'b1};
    tbl[7]  = '{1'b1, 4'h9, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd1, 1'b0};
    tbl[8]  = '{1'b1, 4'h9, 4'h8, 1'b0, 4'h8, 1'b1, 8'h44, 2'd3, 1'b1};
    tbl[9]  = '{1'b1, 4'h9, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd3, 1'b0};
    tbl[10] = '{1'b1, 4'h9, 4'h1, 1'b0, 4'h1, 1'b1, 8'h11, 2'd0, 1'b1};
    tbl[11] = '{1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[12] = '{1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[13] = '{1'b1, 4'h4, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[14] = '{1'b1, 4'h0, 4'h0, 1'b0, 4'h4, 1'b0, 8'h00, 2'd2, 1'b1};
    tbl[15] = '{1'b1, 4'h4, 4'h4, 1'b0, 4'h4, 1'b1, 8'h33, 2'd2, 1'b1};

    w_rst = 1'b0; req_valid = 4'hF; req_last = '0; req_data = '0; full = 1'b0;
    @(posedge w_clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      step_a(tbl[i].rst, tbl[i].v, tbl[i].l, 32'h44332211, tbl[i].f);
      cmp($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].e_ready));
      cmp($sformatf("tbl%0d_wen", i), 32'(w_en), 32'(tbl[i].e_wen));
      cmp($sformatf("tbl%0d_wdata", i), 32'(w_data), 32'(tbl[i].e_wdata));
      cmp($sformatf("tbl%0d_gid", i), 32'(grant_id), 32'(tbl[i].e_gid));
      cmp($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      step_b();
    end

    // Mid-packet reset: abandon requester 1 after two beats, then arbitration restarts at 0.
    wlog.delete();
    for (int k = 0; k < 5; k++) pq[1].push_back({(k == 4), 8'(8'h50 + k)});
    cyc = 0;
    while (wlog.size() < 2 && cyc < 20) begin bfm_step(1'b1, 1'b0); cyc++; end
    cmp("midrst_two_beats", 32'(wlog.size()), 32'd2);
    bfm_step(1'b0, 1'b0);
    cmp("midrst_wen_low", 32'(s_wen), 32'd0);
    cmp("midrst_ready_low", 32'(s_ready), 32'd0);
    pq[3].push_back({1'b1, 8'h5F});
    wlog.delete();
    bfm_run(40, cyc);
    exp.delete();
    for (int k = 2; k < 5; k++) exp.push_back('{id: 1, data: 8'h50 + k});
    exp.push_back('{id: 3, data: 8'h5F});
    check_log("midrst", exp);

    // Round-robin: two 2-beat packets per requester, grants 0,1,2,3,0,1,2,3.
    wlog.delete(); exp.delete();
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < 4; k++) pq[i].push_back({k[0], 8'(i*16 + k)});
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < NREQ; i++)
        for (int k = 0; k < 2; k++) exp.push_back('{id: i, data: i*16 + p*2 + k});
    bfm_run(60, cyc);
    cmp("rr_cycles", 32'(cyc), 32'd24);
    check_log("rr", exp);

    // Full stall of three cycles while requester 2 presents its second beat.
    wlog.delete(); exp.delete();
    for (int k = 0; k < 4; k++) begin
      pq[2].push_back({(k == 3), 8'(8'hA0 + k)});
      exp.push_back('{id: 2, data: 8'hA0 + k});
    end
    b = 0; stall = 3; cyc = 0;
    while (pq[2].size() > 0 && cyc < 30) begin
      f = (b == 1 && stall > 0);
      bfm_step(1'b1, f);
      if (f) begin
        cmp("stall_ready", 32'(s_ready), 32'd0);
        cmp("stall_wen", 32'(s_wen), 32'd0);
        stall--;
      end
      b = 4 - pq[2].size();
      cyc++;
    end
    cmp("stall_done", 32'(stall), 32'd0);
    check_log("stall", exp);
    cmp("stall_ovf", 32'(ovf_drop), 32'd0);

    // Skip and wrap: only 3 and 0 requesting with the pointer at 3.
    wlog.delete(); exp.delete();
    pq[3].push_back({1'b1, 8'hD3});
    pq[0].push_back({1'b1, 8'hD0});
    exp.push_back('{id: 3, data: 8'hD3});
    exp.push_back('{id: 0, data: 8'hD0});
    bfm_run(20, cyc);
    check_log("wrap", exp);

    // Burst cap: 20-beat packet from 1 is split 16 + 4 around requester 3's packet.
    wlog.delete(); exp.delete();
    for (int k = 0; k < 20; k++) pq[1].push_back({(k == 19), 8'(8'h60 + k)});
    pq[3].push_back({1'b0, 8'hC0});
    pq[3].push_back({1'b1, 8'hC1});
    for (int k = 0; k < 16; k++) exp.push_back('{id: 1, data: 8'h60 + k});
    exp.push_back('{id: 3, data: 8'hC0});
    exp.push_back('{id: 3, data: 8'hC1});
    for (int k = 16; k < 20; k++) exp.push_back('{id: 1, data: 8'h60 + k});
    bfm_run(60, cyc);
    cmp("cap_cycles", 32'(cyc), 32'd25);
    check_log("cap", exp);

    // Random traffic against the model, with rare resets.
    for (int n = 0; n < 3000; n++) begin
      step_a(($urandom_range(0, 299) != 0), 4'($urandom), 4'($urandom & $urandom),
             $urandom, ($urandom_range(0, 3) == 0));
      step_b();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
